// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter and its per-source queues.
package cdb_arbiter_pkg;

    localparam int ROB_DEPTH_BITS = 6;
    localparam int DATA_WIDTH     = 32;
    localparam int CDB_FIFO_DEPTH = 4;

    typedef enum logic {
        CDB_SRC_ALU,
        CDB_SRC_DC
    } CdbSrc;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-source result queue: push/pop/flush with head peek and occupancy flags.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter  int DEPTH  = CDB_FIFO_DEPTH,
    parameter  int TAG_W  = ROB_DEPTH_BITS,
    parameter  int DATA_W = DATA_WIDTH,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(DEPTH - 1));

    // A full queue still accepts a push when its head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    assign head_tag  = tag_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem[wr_ptr]  <= in_tag;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Merges ALU results and D-cache load returns onto one registered common data bus.
// Each source has a queue with same-cycle bypass; ties are settled round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH  = CDB_FIFO_DEPTH,
    parameter int TAG_W  = ROB_DEPTH_BITS,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              dc_valid,
    input  logic [TAG_W-1:0]  dc_tag,
    input  logic [DATA_W-1:0] dc_data,
    input  logic              flush,
    input  logic              correct_pred,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              alu_stall,
    output logic              dc_stall,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]  alu_head_tag,  dc_head_tag;
    logic [DATA_W-1:0] alu_head_data, dc_head_data;
    logic [CNT_W-1:0]  alu_count,     dc_count;
    logic              alu_full,      dc_full;
    logic              alu_empty,     dc_empty;
    logic              alu_afull,     dc_afull;

    logic              alu_cand,      dc_cand;
    logic [TAG_W-1:0]  alu_cand_tag,  dc_cand_tag;
    logic [DATA_W-1:0] alu_cand_data, dc_cand_data;
    logic              grant_alu,     grant_dc;
    logic              alu_push,      dc_push;
    logic              alu_pop,       dc_pop;
    logic              tie;
    logic              drop;

    CdbSrc             rr_last;
    logic              vld_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] data_p1;

    // Mispredict-correct notifications carry nothing the bus needs.
    logic unused_inputs;
    assign unused_inputs = correct_pred ^ (^alu_count) ^ (^dc_count);

    cdb_src_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_alu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (alu_push),
        .pop         (alu_pop),
        .flush       (flush),
        .in_tag      (alu_tag),
        .in_data     (alu_result),
        .head_tag    (alu_head_tag),
        .head_data   (alu_head_data),
        .count       (alu_count),
        .full        (alu_full),
        .empty       (alu_empty),
        .almost_full (alu_afull)
    );

    cdb_src_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_dc_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (dc_push),
        .pop         (dc_pop),
        .flush       (flush),
        .in_tag      (dc_tag),
        .in_data     (dc_data),
        .head_tag    (dc_head_tag),
        .head_data   (dc_head_data),
        .count       (dc_count),
        .full        (dc_full),
        .empty       (dc_empty),
        .almost_full (dc_afull)
    );

    // One slot of headroom covers the transaction already in flight.
    assign alu_stall = alu_afull;
    assign dc_stall  = dc_afull;

    // Candidate selection (queue head, else bypass), round-robin grant, queue control.
    always_comb begin
        alu_cand      = !alu_empty || alu_valid;
        alu_cand_tag  = alu_empty ? alu_tag    : alu_head_tag;
        alu_cand_data = alu_empty ? alu_result : alu_head_data;
        dc_cand       = !dc_empty || dc_valid;
        dc_cand_tag   = dc_empty ? dc_tag  : dc_head_tag;
        dc_cand_data  = dc_empty ? dc_data : dc_head_data;

        tie       = alu_cand && dc_cand;
        grant_alu = alu_cand && (!dc_cand || rr_last == CDB_SRC_DC);
        grant_dc  = dc_cand && !grant_alu;

        alu_push  = alu_valid && !(alu_empty && grant_alu);
        dc_push   = dc_valid  && !(dc_empty  && grant_dc);
        alu_pop   = grant_alu && !alu_empty;
        dc_pop    = grant_dc  && !dc_empty;

        drop      = (alu_push && alu_full && !alu_pop) ||
                    (dc_push  && dc_full  && !dc_pop);
    end

    // ---- stage p1: registered CDB, round-robin pointer, sticky overflow ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            tag_p1   <= '0;
            data_p1  <= '0;
            rr_last  <= CDB_SRC_DC;
            overflow <= 1'b0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= grant_alu || grant_dc;
            if (grant_alu) begin
                tag_p1  <= alu_cand_tag;
                data_p1 <= alu_cand_data;
            end else if (grant_dc) begin
                tag_p1  <= dc_cand_tag;
                data_p1 <= dc_cand_data;
            end
            if (tie)  rr_last  <= grant_alu ? CDB_SRC_ALU : CDB_SRC_DC;
            if (drop) overflow <= 1'b1;
        end
    end

    assign cdb_valid = vld_p1;
    assign cdb_tag   = tag_p1;
    assign cdb_data  = data_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference predicts each CDB beat.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int TW = ROB_DEPTH_BITS;
    localparam int DW = DATA_WIDTH;
    localparam int DP = CDB_FIFO_DEPTH;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic [TW-1:0] alu_tag;
    logic [DW-1:0] alu_result;
    logic          dc_valid;
    logic [TW-1:0] dc_tag;
    logic [DW-1:0] dc_data;
    logic          flush;
    logic          correct_pred;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          alu_stall;
    logic          dc_stall;
    logic          overflow;

    cdb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_tag      (alu_tag),
        .alu_result   (alu_result),
        .dc_valid     (dc_valid),
        .dc_tag       (dc_tag),
        .dc_data      (dc_data),
        .flush        (flush),
        .correct_pred (correct_pred),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .alu_stall    (alu_stall),
        .dc_stall     (dc_stall),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct packed {
        logic          v;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    ent_t aq[$];
    ent_t dq[$];
    exp_t sb[$];
    bit   m_rr_dc;
    bit   m_ovf;

    int checks;
    int errors;

    logic          obs_valid;
    logic [TW-1:0] obs_tag;
    logic [DW-1:0] obs_data;

    function automatic void model_reset();
        aq.delete();
        dq.delete();
        sb.delete();
        m_rr_dc = 1'b1;
        m_ovf   = 1'b0;
    endfunction

    // Reference behaviour for one clock: predicts the beat seen after the edge.
    function automatic void model_cycle(input logic av, input logic [TW-1:0] at, input logic [DW-1:0] ad,
                                        input logic dv, input logic [TW-1:0] dt, input logic [DW-1:0] dd,
                                        input logic fl);
        exp_t e;
        ent_t ain;
        ent_t din;
        bit   ac, dcd, ga, gd;
        e        = '0;
        ain.tag  = at;
        ain.data = ad;
        din.tag  = dt;
        din.data = dd;
        if (fl) begin
            aq.delete();
            dq.delete();
        end else begin
            ac  = (aq.size() > 0) || av;
            dcd = (dq.size() > 0) || dv;
            ga  = ac && (!dcd || m_rr_dc);
            gd  = dcd && !ga;
            if (ac && dcd) m_rr_dc = gd;
            if (ga) begin
                e.v = 1'b1;
                if (aq.size() > 0) begin
                    e.tag  = aq[0].tag;
                    e.data = aq[0].data;
                    void'(aq.pop_front());
                    if (av) aq.push_back(ain);
                end else begin
                    e.tag  = at;
                    e.data = ad;
                end
            end else if (av) begin
                if (aq.size() == DP) m_ovf = 1'b1;
                else                 aq.push_back(ain);
            end
            if (gd) begin
                e.v = 1'b1;
                if (dq.size() > 0) begin
                    e.tag  = dq[0].tag;
                    e.data = dq[0].data;
                    void'(dq.pop_front());
                    if (dv) dq.push_back(din);
                end else begin
                    e.tag  = dt;
                    e.data = dd;
                end
            end else if (dv) begin
                if (dq.size() == DP) m_ovf = 1'b1;
                else                 dq.push_back(din);
            end
        end
        sb.push_back(e);
    endfunction

    // Drive one cycle of inputs, clock it, and compare against the scoreboard.
    task automatic step(input logic av, input logic [TW-1:0] at, input logic [DW-1:0] ad,
                        input logic dv, input logic [TW-1:0] dt, input logic [DW-1:0] dd,
                        input logic fl);
        exp_t e;
        logic exp_as, exp_ds;
        alu_valid  = av;
        alu_tag    = at;
        alu_result = ad;
        dc_valid   = dv;
        dc_tag     = dt;
        dc_data    = dd;
        flush      = fl;
        model_cycle(av, at, ad, dv, dt, dd, fl);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (cdb_valid !== e.v) begin
            errors++;
            $display("FAIL sb_valid: got %b expected %b at %0t", cdb_valid, e.v, $time);
        end
        if (e.v) begin
            checks++;
            if (cdb_tag !== e.tag || cdb_data !== e.data) begin
                errors++;
                $display("FAIL sb_beat: got tag %0d data %h expected tag %0d data %h at %0t",
                         cdb_tag, cdb_data, e.tag, e.data, $time);
            end
        end
        exp_as = (aq.size() >= DP - 1);
        exp_ds = (dq.size() >= DP - 1);
        checks++;
        if (alu_stall !== exp_as || dc_stall !== exp_ds) begin
            errors++;
            $display("FAIL sb_stall: got alu %b dc %b expected alu %b dc %b at %0t",
                     alu_stall, dc_stall, exp_as, exp_ds, $time);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL sb_overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
        end
        obs_valid = cdb_valid;
        obs_tag   = cdb_tag;
        obs_data  = cdb_data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        alu_valid  = 1'b0;
        alu_tag    = '0;
        alu_result = '0;
        dc_valid   = 1'b0;
        dc_tag     = '0;
        dc_data    = '0;
        flush      = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0) begin
            errors++;
            $display("FAIL reset_cdb: got v %b tag %0d data %h expected 0 0 0", cdb_valid, cdb_tag, cdb_data);
        end
        checks++;
        if (overflow !== 1'b0 || alu_stall !== 1'b0 || dc_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ovf %b as %b ds %b expected 0 0 0", overflow, alu_stall, dc_stall);
        end
    endtask

    task automatic test_alu_only();
        step(1'b1, 6'd3, 32'h1234, 1'b0, '0, '0, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_tag !== 6'd3 || obs_data !== 32'h1234) begin
            errors++;
            $display("FAIL alu_only_beat: got v %b tag %0d data %h expected 1 3 00001234", obs_valid, obs_tag, obs_data);
        end
        idle(1);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_only_idle: got v %b expected 0", obs_valid);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        step(1'b1, 6'd1, 32'hA001, 1'b1, 6'd2, 32'hD002, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_tag !== 6'd1) begin
            errors++;
            $display("FAIL tie1_first: got v %b tag %0d expected 1 1", obs_valid, obs_tag);
        end
        idle(1);
        checks++;
        if (obs_valid !== 1'b1 || obs_tag !== 6'd2) begin
            errors++;
            $display("FAIL tie1_second: got v %b tag %0d expected 1 2", obs_valid, obs_tag);
        end
        idle(3);
        step(1'b1, 6'd4, 32'hA004, 1'b1, 6'd5, 32'hD005, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_tag !== 6'd5) begin
            errors++;
            $display("FAIL tie2_first: got v %b tag %0d expected 1 5", obs_valid, obs_tag);
        end
        idle(1);
        checks++;
        if (obs_valid !== 1'b1 || obs_tag !== 6'd4) begin
            errors++;
            $display("FAIL tie2_second: got v %b tag %0d expected 1 4", obs_valid, obs_tag);
        end
    endtask

    // Both producers hold off one cycle after seeing their stall.
    task automatic test_back_pressure();
        logic s_now_a, s_now_d, s_prev_a, s_prev_d, av, dv;
        bit   seen_ds;
        int   at, dt;
        s_now_a = 1'b0; s_now_d = 1'b0; s_prev_a = 1'b0; s_prev_d = 1'b0;
        seen_ds = 0;
        at = 8;
        dt = 32;
        for (int i = 0; i < 24; i++) begin
            av = !s_prev_a;
            dv = !s_prev_d;
            step(av, TW'(at), DW'($urandom), dv, TW'(dt), DW'($urandom), 1'b0);
            if (av) at = (at == 31) ? 8 : at + 1;
            if (dv) dt = (dt == 63) ? 32 : dt + 1;
            s_prev_a = s_now_a;
            s_prev_d = s_now_d;
            s_now_a  = alu_stall;
            s_now_d  = dc_stall;
            if (dc_stall) seen_ds = 1;
        end
        idle(10);
        checks++;
        if (seen_ds !== 1'b1) begin
            errors++;
            $display("FAIL bp_dc_stall_seen: got %b expected 1", seen_ds);
        end
        checks++;
        if (overflow !== 1'b0 || alu_stall !== 1'b0 || dc_stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_end_flags: got ovf %b as %b ds %b expected 0 0 0", overflow, alu_stall, dc_stall);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 14; i++)
            step(1'b1, TW'(8 + i), DW'($urandom), 1'b1, TW'(40 + i), DW'($urandom), 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", overflow);
        end
        idle(12);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_flush();
        int late_valid;
        for (int i = 0; i < 6; i++)
            step(1'b1, TW'(16 + i), DW'($urandom), 1'b1, TW'(48 + i), DW'($urandom), 1'b0);
        step(1'b1, 6'd30, 32'hF00D, 1'b0, '0, '0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0 || alu_stall !== 1'b0 || dc_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_next: got v %b as %b ds %b expected 0 0 0", obs_valid, alu_stall, dc_stall);
        end
        late_valid = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (obs_valid) late_valid++;
        end
        checks++;
        if (late_valid != 0) begin
            errors++;
            $display("FAIL flush_stale: got %0d beats expected 0", late_valid);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 6'd10, 32'h10, 1'b1, 6'd50, 32'h50, 1'b0);
        step(1'b1, 6'd11, 32'h11, 1'b1, 6'd51, 32'h51, 1'b0);
        alu_valid = 1'b0;
        dc_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got v %b ovf %b expected 0 0", cdb_valid, overflow);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 6'd7, 32'h7, 1'b1, 6'd9, 32'h9, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_tag !== 6'd7) begin
            errors++;
            $display("FAIL midreset_tie: got v %b tag %0d expected 1 7", obs_valid, obs_tag);
        end
        idle(2);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        correct_pred = 1'b0;
        obs_valid    = 1'b0;
        obs_tag      = '0;
        obs_data     = '0;
        test_reset();
        test_alu_only();
        test_tie();
        test_back_pressure();
        test_overflow();
        test_flush();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
